maxpool_ctrl: RTL and testbench
===============================

MAXPOOL_CTRL -- requirements
Module: maxpool_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning element width in bits, signed two's complement.
REQ-002 The block SHALL have parameter LEN, default 16, meaning input elements per channel.
REQ-003 The block SHALL have parameter CHANNELS, default 32, meaning number of channels per job.
REQ-004 The block SHALL have parameter KERNEL, default 2, meaning pooling window size, 1..LEN.
REQ-005 The block SHALL have parameter STRIDE, default 2, meaning window step, >=1.
REQ-006 The block SHALL have parameter ADDR_W, default 10, meaning memory address width.
REQ-007 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-009 The block SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-010 The block SHALL have port abort, input, 1 bit: terminates the job in progress.
REQ-011 The block SHALL have port rd_en, output, 1 bit: input-memory read request.
REQ-012 The block SHALL have port rd_addr, output, ADDR_W bits: read address.
REQ-013 The block SHALL have port rd_gnt, input, 1 bit: shared-memory arbiter grant.
REQ-014 The block SHALL have port rd_data, input, DATA_W bits: read data, valid one cycle after an accepted read.
REQ-015 The block SHALL have port wr_en, output, 1 bit: output-memory write strobe.
REQ-016 The block SHALL have port wr_addr, output, ADDR_W bits: write address.
REQ-017 The block SHALL have port wr_data, output, DATA_W bits: pooled result.
REQ-018 The block SHALL have port busy, output, 1 bit: high outside IDLE.
REQ-019 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-020 The block SHALL compute OUT_LEN = (LEN-KERNEL)/STRIDE+1, which is 8 at defaults.
REQ-021 The FSM SHALL have states IDLE, READ, WAIT, WRITE and DONE.
REQ-022 Transitions SHALL be: IDLE->READ on start; READ->WAIT after KERNEL accepted reads; WAIT->WRITE; WRITE->READ if windows remain, else ->DONE; DONE->IDLE.
REQ-023 Windows SHALL be processed channel-major: ch 0..CHANNELS-1, then o 0..OUT_LEN-1 within each channel.
REQ-024 For window element k, rd_addr SHALL equal ch*LEN + o*STRIDE + k.
REQ-025 A read SHALL be accepted only in a cycle with rd_en=1 and rd_gnt=1; while rd_gnt=0, rd_en and rd_addr SHALL hold stable.
REQ-026 The running max SHALL load the element k=0 datum and then take the signed maximum of each later datum; ties SHALL keep the stored value.
REQ-027 In WRITE, the block SHALL assert wr_en for exactly one cycle, with wr_addr = ch*OUT_LEN + o and wr_data = the window maximum.
REQ-028 With rd_gnt held at 1, each window SHALL take KERNEL+2 cycles; a default job SHALL take 1024 cycles from the first READ to DONE.
REQ-029 done SHALL pulse for one cycle in DONE; busy SHALL be 0 only in IDLE.
REQ-030 start asserted outside IDLE SHALL be ignored.
REQ-031 abort SHALL return the FSM to IDLE on the next edge with no further wr_en and no done pulse; abort SHALL take priority over every other transition.
REQ-032 If start and abort are both high in IDLE, the FSM SHALL remain in IDLE.
REQ-033 Address counters SHALL reset to 0 at each job start.

Reset
REQ-034 While rst_n=0, the FSM SHALL be in IDLE and rd_en, rd_addr, wr_en, wr_addr, wr_data, busy and done SHALL all be 0.
REQ-035 Reset asserted mid-job SHALL discard the job without issuing a write.

Configuration
REQ-036 With MAXPOOL_CTRL_RELU_EN defined, wr_data SHALL be clamped to 0 when the window maximum is negative.
REQ-037 Without MAXPOOL_CTRL_RELU_EN defined, wr_data SHALL pass the signed maximum unchanged.

Verification
REQ-038 Defaults, mem[i]=i, rd_gnt=1, start pulse -> 256 writes; write 0 is addr 0, data 1; write 255 is addr 255, data 511; done pulses 1024 cycles after READ entry.
REQ-039 rd_gnt low for 5 cycles during the second read of window 0 -> rd_addr stays 1 throughout; the result is unchanged; the job completes 5 cycles late.
REQ-040 mem[0]=-3, mem[1]=-7 -> wr_data=-3 without the macro, 0 with MAXPOOL_CTRL_RELU_EN.
REQ-041 abort asserted in WRITE of window 10 -> no wr_en that cycle or afterwards; busy=0 next cycle; done never pulses; a new start re-runs from address 0.
REQ-042 start re-pulsed while busy, plus rst_n low mid-job -> start is ignored; all outputs are 0 during reset; IDLE is entered immediately.

Source files
------------

// File: rtl/maxpool_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | maxpool_ctrl: 1-D max-pooling job controller (read window, write max).   |
// | Optional: define MAXPOOL_CTRL_RELU_EN to clamp negative results to 0.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module maxpool_ctrl #(
  parameter int DATA_W   = 16,
  parameter int LEN      = 16,
  parameter int CHANNELS = 32,
  parameter int KERNEL   = 2,
  parameter int STRIDE   = 2,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam int OUT_LEN = (LEN - KERNEL) / STRIDE + 1;
  localparam int KW      = (KERNEL > 1) ? $clog2(KERNEL) : 1;
  localparam logic [KW-1:0]     K_LAST   = KW'(KERNEL - 1);
  localparam logic [ADDR_W-1:0] O_LAST   = ADDR_W'(OUT_LEN - 1);
  localparam logic [ADDR_W-1:0] CH_LAST  = ADDR_W'(CHANNELS - 1);
  localparam logic [ADDR_W-1:0] LEN_A    = ADDR_W'(LEN);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [ADDR_W-1:0]  o_q, o_d, ch_q, ch_d;
  logic [ADDR_W-1:0]  ch_base_q, ch_base_d, win_base_q, win_base_d;
  logic [ADDR_W-1:0]  wr_idx_q, wr_idx_d;
  logic [DATA_W-1:0]  max_q, max_d, max_new;
  logic               pend_q, pend_d, pend_first_q, pend_first_d;
  logic               rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               accept, last_win;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    o_d          = o_q;
    ch_d         = ch_q;
    ch_base_d    = ch_base_q;
    win_base_d   = win_base_q;
    wr_idx_d     = wr_idx_q;
    rd_en_d      = 1'b0;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    done_d       = 1'b0;
    pend_d       = 1'b0;
    pend_first_d = 1'b0;
    accept       = (state_q == S_READ) && rd_en_q && rd_gnt;
    last_win     = (o_q == O_LAST) && (ch_q == CH_LAST);

    // rd_data is only meaningful in the cycle after an accepted read
    max_new = max_q;
    if (pend_q && (pend_first_q || ($signed(rd_data) > $signed(max_q)))) begin
      max_new = rd_data;
    end
    max_d = max_new;

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_READ;
            k_d        = '0;
            o_d        = '0;
            ch_d       = '0;
            ch_base_d  = '0;
            win_base_d = '0;
            wr_idx_d   = '0;
            rd_en_d    = 1'b1;
            rd_addr_d  = '0;
          end
        end
        S_READ: begin
          rd_en_d = 1'b1;
          if (accept) begin
            pend_d       = 1'b1;
            pend_first_d = (k_q == '0);
            if (k_q == K_LAST) begin
              state_d = S_WAIT;
              rd_en_d = 1'b0;
            end else begin
              k_d       = k_q + 1'b1;
              rd_addr_d = rd_addr_q + 1'b1;
            end
          end
        end
        S_WAIT: begin
          state_d   = S_WRITE;
          wr_en_d   = 1'b1;
          wr_addr_d = wr_idx_q;
`ifdef MAXPOOL_CTRL_RELU_EN
          wr_data_d = max_new[DATA_W-1] ? '0 : max_new;
`else
          wr_data_d = max_new;
`endif
        end
        S_WRITE: begin
          wr_idx_d = wr_idx_q + 1'b1;
          k_d      = '0;
          if (last_win) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_READ;
            rd_en_d = 1'b1;
            if (o_q == O_LAST) begin
              o_d        = '0;
              ch_d       = ch_q + 1'b1;
              ch_base_d  = ch_base_q + LEN_A;
              win_base_d = ch_base_q + LEN_A;
              rd_addr_d  = ch_base_q + LEN_A;
            end else begin
              o_d        = o_q + 1'b1;
              win_base_d = win_base_q + STRIDE_A;
              rd_addr_d  = win_base_q + STRIDE_A;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      k_q          <= '0;
      o_q          <= '0;
      ch_q         <= '0;
      ch_base_q    <= '0;
      win_base_q   <= '0;
      wr_idx_q     <= '0;
      max_q        <= '0;
      pend_q       <= 1'b0;
      pend_first_q <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      o_q          <= o_d;
      ch_q         <= ch_d;
      ch_base_q    <= ch_base_d;
      win_base_q   <= win_base_d;
      wr_idx_q     <= wr_idx_d;
      max_q        <= max_d;
      pend_q       <= pend_d;
      pend_first_q <= pend_first_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // abort suppresses a write or done pulse already staged for this cycle
  assign wr_en   = wr_en_q & ~abort;
  assign done    = done_q & ~abort;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_maxpool_ctrl: randomized self-checking bench for maxpool_ctrl.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_maxpool_ctrl;
  localparam int DATA_W   = 16;
  localparam int LEN      = 16;
  localparam int CHANNELS = 32;
  localparam int KERNEL   = 2;
  localparam int STRIDE   = 2;
  localparam int ADDR_W   = 10;
  localparam int OUT_LEN  = (LEN - KERNEL) / STRIDE + 1;
  localparam int NWIN     = CHANNELS * OUT_LEN;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              rd_gnt = 1'b1;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;

  logic signed [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wq_addr [$];
  logic [DATA_W-1:0] wq_data [$];
  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int start_cyc = 0;
  logic busy_prev = 1'b0;

  maxpool_ctrl #(
    .DATA_W(DATA_W), .LEN(LEN), .CHANNELS(CHANNELS),
    .KERNEL(KERNEL), .STRIDE(STRIDE), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Memory: data only valid the cycle after an accepted read, garbage otherwise
  always @(posedge clk) begin
    if (rd_en && rd_gnt) rd_data <= mem[rd_addr];
    else                 rd_data <= DATA_W'($urandom);
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (busy && !busy_prev) start_cyc <= cyc;
    busy_prev <= busy;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected pooled value of window w, straight from the pooling definition
  function automatic logic [DATA_W-1:0] ref_out(int w);
    int ch = w / OUT_LEN;
    int o  = w % OUT_LEN;
    int b  = ch * LEN + o * STRIDE;
    logic signed [DATA_W-1:0] m = mem[b];
    for (int k = 1; k < KERNEL; k++) if (mem[b+k] > m) m = mem[b+k];
`ifdef MAXPOOL_CTRL_RELU_EN
    if (m < 0) m = '0;
`endif
    return m;
  endfunction

  function automatic int ref_addr(int w);
    return (w / OUT_LEN) * OUT_LEN + (w % OUT_LEN);
  endfunction

  task automatic fill_ramp();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic start_job();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != n0) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b want 0", rd_en); else passes++;
    checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr got %0d want 0", rd_addr); else passes++;
    checks++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en got %b want 0", wr_en); else passes++;
    checks++; if (wr_addr !== '0) $display("FAIL reset_wr_addr got %0d want 0", wr_addr); else passes++;
    checks++; if (wr_data !== '0) $display("FAIL reset_wr_data got %0h want 0", wr_data); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_ramp_job();
    bit ok;
    int d0;
    fill_ramp(); clear_log(); rd_gnt = 1'b1;
    d0 = done_cnt;
    start_job();
    wait_done(1100, ok);
    repeat (3) @(posedge clk); #1;
    checks++; if (!ok) $display("FAIL ramp_done_timeout got 0 want 1"); else passes++;
    checks++; if (wq_addr.size() != NWIN) $display("FAIL ramp_write_count got %0d want %0d", wq_addr.size(), NWIN); else passes++;
    if (wq_addr.size() == NWIN) begin
      checks++; if (wq_addr[0] !== 10'd0 || wq_data[0] !== 16'd1)
        $display("FAIL ramp_first_write got a=%0d d=%0d want a=0 d=1", wq_addr[0], wq_data[0]); else passes++;
      checks++; if (wq_addr[NWIN-1] !== 10'd255 || wq_data[NWIN-1] !== 16'd511)
        $display("FAIL ramp_last_write got a=%0d d=%0d want a=255 d=511", wq_addr[NWIN-1], wq_data[NWIN-1]); else passes++;
    end
    checks++; if (done_cyc - start_cyc != 1024) $display("FAIL ramp_job_cycles got %0d want 1024", done_cyc - start_cyc); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL ramp_done_pulse_len got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL ramp_idle_busy got %b want 0", busy); else passes++;
  endtask

  task automatic test_random_data();
    bit ok;
    int bad = 0;
    fill_rand(); clear_log(); rd_gnt = 1'b1;
    start_job();
    wait_done(1100, ok);
    checks++; if (!ok) $display("FAIL rand_done_timeout got 0 want 1"); else passes++;
    checks++; if (wq_addr.size() != NWIN) $display("FAIL rand_write_count got %0d want %0d", wq_addr.size(), NWIN); else passes++;
    for (int w = 0; w < NWIN && w < wq_addr.size(); w++) begin
      checks++;
      if (wq_addr[w] !== ADDR_W'(ref_addr(w)) || wq_data[w] !== ref_out(w)) begin
        if (bad < 5) $display("FAIL rand_write[%0d] got a=%0d d=%0h want a=%0d d=%0h",
                              w, wq_addr[w], wq_data[w], ref_addr(w), ref_out(w));
        bad++;
      end else passes++;
    end
  endtask

  task automatic test_random_gnt();
    int n0 = done_cnt;
    int bad = 0;
    int i;
    fill_rand(); clear_log(); rd_gnt = 1'b1;
    start_job();
    for (i = 0; i < 5000 && done_cnt == n0; i++) begin
      @(posedge clk); #1 rd_gnt = ($urandom_range(0, 3) != 0);
    end
    rd_gnt = 1'b1;
    checks++; if (done_cnt == n0) $display("FAIL rgnt_done_timeout got 0 want 1"); else passes++;
    checks++; if (wq_addr.size() != NWIN) $display("FAIL rgnt_write_count got %0d want %0d", wq_addr.size(), NWIN); else passes++;
    for (int w = 0; w < NWIN && w < wq_addr.size(); w++) begin
      checks++;
      if (wq_addr[w] !== ADDR_W'(ref_addr(w)) || wq_data[w] !== ref_out(w)) begin
        if (bad < 5) $display("FAIL rgnt_write[%0d] got a=%0d d=%0h want a=%0d d=%0h",
                              w, wq_addr[w], wq_data[w], ref_addr(w), ref_out(w));
        bad++;
      end else passes++;
    end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_stall();
    bit ok;
    int bad = 0;
    fill_ramp(); clear_log(); rd_gnt = 1'b1;
    start_job();
    @(posedge clk); #1 rd_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (rd_en !== 1'b1 || rd_addr !== 10'd1)
        $display("FAIL stall_hold[%0d] got en=%b a=%0d want en=1 a=1", i, rd_en, rd_addr); else passes++;
      @(posedge clk); #1;
    end
    rd_gnt = 1'b1;
    wait_done(1200, ok);
    checks++; if (!ok) $display("FAIL stall_done_timeout got 0 want 1"); else passes++;
    checks++; if (done_cyc - start_cyc != 1029) $display("FAIL stall_job_cycles got %0d want 1029", done_cyc - start_cyc); else passes++;
    checks++; if (wq_addr.size() != NWIN) $display("FAIL stall_write_count got %0d want %0d", wq_addr.size(), NWIN); else passes++;
    for (int w = 0; w < NWIN && w < wq_addr.size(); w++) begin
      checks++;
      if (wq_data[w] !== ref_out(w)) begin
        if (bad < 5) $display("FAIL stall_write[%0d] got d=%0d want d=%0d", w, wq_data[w], ref_out(w));
        bad++;
      end else passes++;
    end
  endtask

  task automatic test_negative();
    bit ok;
    logic [DATA_W-1:0] exp0;
    fill_rand(); clear_log(); rd_gnt = 1'b1;
    mem[0] = -16'sd3;
    mem[1] = -16'sd7;
`ifdef MAXPOOL_CTRL_RELU_EN
    exp0 = 16'd0;
`else
    exp0 = 16'hFFFD;
`endif
    start_job();
    wait_done(1100, ok);
    checks++; if (!ok) $display("FAIL neg_done_timeout got 0 want 1"); else passes++;
    checks++; if (wq_data.size() == 0 || wq_data[0] !== exp0)
      $display("FAIL neg_window0 got %0h want %0h", (wq_data.size() != 0) ? wq_data[0] : 16'hxxxx, exp0); else passes++;
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    fill_ramp(); clear_log(); rd_gnt = 1'b1;
    d0 = done_cnt;
    start_job();
    repeat (43) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0) $display("FAIL abort_wr_en got %b want 0", wr_en); else passes++;
    checks++; if (wq_addr.size() != 10) $display("FAIL abort_writes_before got %0d want 10", wq_addr.size()); else passes++;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passes++;
    repeat (60) @(posedge clk); #1;
    checks++; if (wq_addr.size() != 10) $display("FAIL abort_writes_after got %0d want 10", wq_addr.size()); else passes++;
    checks++; if (done_cnt != d0) $display("FAIL abort_done got %0d want 0", done_cnt - d0); else passes++;
    clear_log();
    start_job();
    wait_done(1100, ok);
    checks++; if (!ok) $display("FAIL rerun_done_timeout got 0 want 1"); else passes++;
    checks++; if (wq_addr.size() != NWIN) $display("FAIL rerun_write_count got %0d want %0d", wq_addr.size(), NWIN); else passes++;
    checks++; if (wq_addr.size() == 0 || wq_addr[0] !== 10'd0 || wq_data[0] !== 16'd1)
      $display("FAIL rerun_first_write got a=%0d d=%0d want a=0 d=1",
               (wq_addr.size() != 0) ? wq_addr[0] : 10'd0, (wq_data.size() != 0) ? wq_data[0] : 16'd0); else passes++;
  endtask

  task automatic test_start_reset();
    int n;
    int d0;
    fill_ramp(); clear_log(); rd_gnt = 1'b1;
    d0 = done_cnt;
    start_job();
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (17) @(posedge clk); #1;
    checks++; if (wq_addr.size() != 9) $display("FAIL restart_write_count got %0d want 9", wq_addr.size()); else passes++;
    for (int w = 0; w < wq_addr.size(); w++) begin
      checks++;
      if (wq_addr[w] !== ADDR_W'(w) || wq_data[w] !== ref_out(w))
        $display("FAIL restart_write[%0d] got a=%0d d=%0d want a=%0d d=%0d", w, wq_addr[w], wq_data[w], w, ref_out(w));
      else passes++;
    end
    n = wq_addr.size();
    rst_n = 1'b0;
    #1;
    checks++; if ({rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done} !== '0)
      $display("FAIL midjob_reset_outputs got en=%b ra=%0d we=%b wa=%0d wd=%0d busy=%b done=%b want all 0",
               rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done); else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rd_en !== 1'b0) $display("FAIL midjob_reset_hold got busy=%b rd_en=%b want 0 0", busy, rd_en); else passes++;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    checks++; if (wq_addr.size() != n) $display("FAIL midjob_reset_writes got %0d want %0d", wq_addr.size(), n); else passes++;
    checks++; if (done_cnt != d0 || busy !== 1'b0)
      $display("FAIL midjob_reset_idle got done=%0d busy=%b want 0 0", done_cnt - d0, busy); else passes++;
  endtask

  initial begin
    test_reset();
    test_ramp_job();
    test_random_data();
    test_random_gnt();
    test_stall();
    test_negative();
    test_abort();
    test_start_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
